// File: rtl/sc_dot_product.sv
// Stochastic-computing dot product.
// Each element pair is multiplied with a single gate: XNOR for bipolar
// streams, AND for unipolar streams. A multiplexer driven by uncorrelated
// select streams then picks one product bit per cycle. This is a scaled
// adder, so the output stream has an expected value of (1/LENGTH)*sum(prod).
// The datapath is two registers deep and accepts a new vector every cycle.
// A two-bit shift chain marks which result bits come from post-reset inputs.
module sc_dot_product #(
  parameter int LENGTH       = 4,  // number of element pairs, at least 2
  parameter int SELECT_WIDTH = 2,  // clog2(LENGTH)
  parameter int BIPOLAR      = 1   // 1: XNOR multiply, 0: AND multiply
) (
  input  logic                    clk,
  input  logic                    rst,      // synchronous, active low
  input  logic [LENGTH-1:0]       data,
  input  logic [LENGTH-1:0]       weights,
  input  logic [SELECT_WIDTH-1:0] sel,
  output logic                    result,
  output logic                    valid
);

  // Every value sel can take has a slot in the padded vector.
  localparam int PADDED = 1 << SELECT_WIDTH;

  logic [LENGTH-1:0]       prod;
  logic [LENGTH-1:0]       prod_r;
  logic [SELECT_WIDTH-1:0] sel_r;
  logic [PADDED-1:0]       prod_pad;
  logic [1:0]              chain;

  // Stage 0: bitwise stochastic multiply, chosen once at elaboration.
  generate
    if (BIPOLAR != 0) begin : g_bipolar
      assign prod = ~(data ^ weights);
    end else begin : g_unipolar
      assign prod = data & weights;
    end
  endgenerate

  // Pad the products out to the full select range with zeros. A select
  // value past the last element then reads a 0 and needs no extra compare.
  // The generate-if never creates an out-of-range part select.
  generate
    for (genvar g = 0; g < PADDED; g++) begin : g_pad
      if (g < LENGTH) begin : g_real
        assign prod_pad[g] = prod_r[g];
      end else begin : g_zero
        assign prod_pad[g] = 1'b0;
      end
    end
  endgenerate

  // Stage 1: register the products and sel together so they stay aligned.
  // NOTE: registers use non-blocking assignments. Every flop then samples
  // the pre-edge value, and the result does not depend on the order in
  // which the simulator runs the always blocks.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prod_r <= '0;
      sel_r  <= '0;
    end else begin
      prod_r <= prod;
      sel_r  <= sel;
    end
  end

  // Stage 2: the multiplexer scaled adder picks one product bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      result <= 1'b0;
    end else begin
      result <= prod_pad[sel_r];
    end
  end

  // Valid chain: fills with ones after reset and tracks the two-stage depth.
  always_ff @(posedge clk) begin
    if (!rst) begin
      chain <= 2'b00;
    end else begin
      chain <= {chain[0], 1'b1};
    end
  end

  assign valid = chain[1];

endmodule

// File: tb/tb_sc_dot_product.sv
// Self-checking bench for sc_dot_product.
// Three instances are driven in parallel: bipolar LENGTH=4, unipolar LENGTH=4
// and bipolar LENGTH=3. A behavioural model works out the expected result
// from the inputs and reset level sampled at each clock edge. One compare
// process checks every instance on every falling edge. Hand-computed literal
// expectations pin the directed cases.
module tb_sc_dot_product;

  typedef struct packed {
    logic [3:0] data;
    logic [3:0] weights;
    logic [1:0] sel;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] data_a, weights_a, data_b, weights_b;
  logic [2:0] data_c, weights_c;
  logic [1:0] sel_a, sel_b, sel_c;
  logic       result_a, valid_a, result_b, valid_b, result_c, valid_c;

  sc_dot_product #(.LENGTH(4), .SELECT_WIDTH(2), .BIPOLAR(1)) dut_a (
    .clk(clk), .rst(rst), .data(data_a), .weights(weights_a), .sel(sel_a),
    .result(result_a), .valid(valid_a));

  sc_dot_product #(.LENGTH(4), .SELECT_WIDTH(2), .BIPOLAR(0)) dut_b (
    .clk(clk), .rst(rst), .data(data_b), .weights(weights_b), .sel(sel_b),
    .result(result_b), .valid(valid_b));

  sc_dot_product #(.LENGTH(3), .SELECT_WIDTH(2), .BIPOLAR(1)) dut_c (
    .clk(clk), .rst(rst), .data(data_c), .weights(weights_c), .sel(sel_c),
    .result(result_c), .valid(valid_c));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of one output bit: the product of the selected element
  // pair, or 0 when sel points past the last element.
  function automatic logic model_bit(input vec_t v, input int len, input bit bipolar);
    int s;
    s = int'(v.sel);
    if (s >= len) return 1'b0;
    if (bipolar) return (v.data[s] == v.weights[s]);
    return v.data[s] & v.weights[s];
  endfunction

  // Number of product bits that are 1 in a bipolar LENGTH=4 vector.
  function automatic int bipolar_ones(input vec_t v);
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) if (v.data[i] == v.weights[i]) n++;
    return n;
  endfunction

  int   lens[3]    = '{4, 4, 3};
  bit   bips[3]    = '{1'b1, 1'b0, 1'b1};
  vec_t now_v[3];
  vec_t cur_v[3];
  vec_t prev_v[3];
  logic cur_rst  = 1'b0;
  logic prev_rst = 1'b0;
  logic started  = 1'b0;
  logic res[3];
  logic vld[3];

  assign now_v[0] = {data_a, weights_a, sel_a};
  assign now_v[1] = {data_b, weights_b, sel_b};
  assign now_v[2] = {1'b0, data_c, 1'b0, weights_c, sel_c};
  assign res[0] = result_a;
  assign res[1] = result_b;
  assign res[2] = result_c;
  assign vld[0] = valid_a;
  assign vld[1] = valid_b;
  assign vld[2] = valid_c;

  // Record the reset level and input vector sampled at each rising edge.
  always @(posedge clk) begin
    prev_rst <= cur_rst;
    cur_rst  <= rst;
    started  <= 1'b1;
    for (int k = 0; k < 3; k++) begin
      prev_v[k] <= cur_v[k];
      cur_v[k]  <= now_v[k];
    end
  end

  // Model rule. After edge n, the output is valid only if reset was high at
  // both edge n and edge n-1. A valid result is the product picked from the
  // vector sampled at edge n-1. Any other result is 0.
  logic  measuring = 1'b0;
  int    meas_n    = 0;
  int    meas_ones = 0;
  real   meas_exp  = 0.0;

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        logic ok;
        logic exp_res;
        ok      = cur_rst && prev_rst;
        exp_res = ok ? model_bit(prev_v[k], lens[k], bips[k]) : 1'b0;
        check($sformatf("valid[%0d]", k), {31'd0, vld[k]}, {31'd0, ok});
        check($sformatf("result[%0d]", k), {31'd0, res[k]}, {31'd0, exp_res});
      end
      if (measuring && valid_a) begin
        meas_n++;
        meas_ones += int'(result_a);
        meas_exp  += real'(bipolar_ones(prev_v[0])) / 4.0;
      end
    end
  end

  task automatic drive_random();
    data_a    = 4'($urandom);
    weights_a = 4'($urandom);
    sel_a     = 2'($urandom);
    data_b    = 4'($urandom);
    weights_b = 4'($urandom);
    sel_b     = 2'($urandom);
    data_c    = 3'($urandom);
    weights_c = 3'($urandom);
    sel_c     = 2'($urandom);
  endtask

  logic [3:0] b_sweep_exp;
  int         pd[4];
  int         pw[4];

  initial begin
    rst = 1'b0;
    data_a = '0; weights_a = '0; sel_a = '0;
    data_b = '0; weights_b = '0; sel_b = '0;
    data_c = '0; weights_c = '0; sel_c = '0;
    b_sweep_exp = 4'b0110;

    // Reset held low for eight edges with random inputs applied. The
    // outputs must stay 0 throughout.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive_random();
      if (i > 0) begin
        check("reset_result_a", {31'd0, result_a}, 32'd0);
        check("reset_valid_a", {31'd0, valid_a}, 32'd0);
      end
    end

    // Release, then the directed vectors.
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 1) check("valid_one_edge_after_release", {31'd0, valid_a}, 32'd0);
      if (i >= 2) begin
        check("valid_two_edges_after_release", {31'd0, valid_a}, 32'd1);
        if (i == 2) check("bipolar_sel2", {31'd0, result_a}, 32'd1);
        if (i == 3) check("bipolar_sel0", {31'd0, result_a}, 32'd0);
        check($sformatf("unipolar_sweep_sel%0d", i - 2), {31'd0, result_b},
              {31'd0, b_sweep_exp[i-2]});
        if (i == 2) check("len3_sel3_zero", {31'd0, result_c}, 32'd0);
      end
      if (i < 4) begin
        data_a    = 4'b1010;
        weights_a = 4'b1001;
        sel_a     = (i == 0) ? 2'd2 : 2'd0;
        data_b    = 4'b1111;
        weights_b = 4'b0110;
        sel_b     = 2'(i);
        data_c    = 3'b111;
        weights_c = 3'b111;
        sel_c     = 2'd3;
      end
    end

    // 100 random vectors with a single-cycle reset in the middle.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 51) begin
        check("midreset_valid_cleared", {31'd0, valid_a}, 32'd0);
        check("midreset_result_cleared", {31'd0, result_a}, 32'd0);
      end
      if (i == 53) check("midreset_valid_back", {31'd0, valid_a}, 32'd1);
      rst = (i == 50) ? 1'b0 : 1'b1;
      drive_random();
    end

    // Long run of stochastic streams with fixed per-element probabilities.
    // The mean of result must track sum(prod)/4.
    for (int i = 0; i < 4; i++) begin
      pd[i] = int'($urandom_range(0, 100));
      pw[i] = int'($urandom_range(0, 100));
    end
    measuring = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        data_a[i]    = (int'($urandom_range(0, 99)) < pd[i]);
        weights_a[i] = (int'($urandom_range(0, 99)) < pw[i]);
      end
      sel_a     = 2'($urandom);
      data_b    = 4'($urandom);
      weights_b = 4'($urandom);
      sel_b     = 2'($urandom);
      data_c    = 3'($urandom);
      weights_c = 3'($urandom);
      sel_c     = 2'($urandom);
    end
    repeat (3) @(negedge clk);
    measuring = 1'b0;

    begin
      real got_mean;
      real exp_mean;
      real diff;
      checks++;
      if (meas_n == 0) begin
        errors++;
        $display("FAIL mean_run: no valid samples collected");
      end else begin
        got_mean = real'(meas_ones) / real'(meas_n);
        exp_mean = meas_exp / real'(meas_n);
        diff     = got_mean - exp_mean;
        if (diff < 0.0) diff = -diff;
        if (diff > 0.05) begin
          errors++;
          $display("FAIL mean_run: got %f expected %f", got_mean, exp_mean);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
